keypad_scan: RTL and testbench
==============================

# keypad_scan

Matrix-keypad scanner for the board's 4×4 hex keypad, the input-side counterpart of the multiplexed seven-segment display driver. It drives the row lines one at a time and samples the column lines, debouncing press and release. It emits a one-cycle strobe with a 4-bit key code and keeps a 2-digit history register. That register's `key_digits[7:0]` connects straight to the display driver's 8-bit digit input.

## Interface
- `SCAN_DIV_BITS`, default 16: scan tick period is 2^SCAN_DIV_BITS clocks (1.31 ms at 50 MHz); legal range 2..24.
- `DEBOUNCE_TICKS`, default 8: consecutive agreeing ticks required to accept a press or a release; legal range 1..15.
- `clk_50M` input 1: board 50 MHz clock; all flops on its rising edge.
- `rst_button` input 1: reset, asynchronous, active-high.
- `key_col` input 4: column lines, pulled up, active-low, asynchronous to the clock.
- `key_row` output 4: row drive, active-low, exactly one bit low at all times.
- `key_code` output 4: code of the last accepted key, `{row[1:0], col[1:0]}`.
- `key_valid` output 1: one-cycle pulse when a press is accepted.
- `key_held` output 1: high while an accepted key remains pressed.
- `key_digits` output 8: last two accepted codes; newest in `[3:0]`.

## Operation
- **Divider:** free-running counter of SCAN_DIV_BITS bits. `tick` is high for one cycle when the counter equals all-ones, then the counter wraps to 0.
- **Synchronizer:** `key_col` passes through 2 flops, both reset to 4'hF; `col_s` is the second flop. All FSM decisions use `col_s` sampled on `tick` only.
- **Row drive:** `key_row = ~(4'b0001 << r)`. Row index `r` (2 bits) changes only on `tick`, so each row settles for a full tick period before sampling.
- **Column select:** `c` = lowest-index low bit of `col_s`. Multiple keys in one row resolve to the lowest column.
- **SCAN:**
  - On tick with `col_s == 4'hF`: `r <= r+1` (3 wraps to 0).
  - On tick with any bit low: latch `c`, `cnt <= 1`, go to DEBOUNCE; `r` is held.
- **DEBOUNCE:** on tick, check `col_s[c]`.
  - Low and `cnt == DEBOUNCE_TICKS`: accept, go to HELD.
  - Low otherwise: `cnt++`.
  - High: abort, `r <= r+1`, go to SCAN, no output change.
  - With DEBOUNCE_TICKS = 1, acceptance occurs on the first tick in DEBOUNCE.
- **Accept (registered, same clock edge):**
  - `key_code <= {r, c}`.
  - `key_digits <= {key_digits[3:0], {r, c}}`.
  - `key_valid <= 1` for exactly one cycle.
  - `key_held <= 1`.
- **HELD:** `r` is held and other keys are ignored. On tick with `col_s[c]` high: `cnt <= 1`, go to RELEASE.
- **RELEASE:** on tick, check `col_s[c]`.
  - Low: back to HELD (bounce).
  - High and `cnt == DEBOUNCE_TICKS`: `key_held <= 0`, `r <= r+1`, go to SCAN.
  - High otherwise: `cnt++`.
- `cnt` is 4 bits and never exceeds DEBOUNCE_TICKS. A press produces exactly one `key_valid`; there is no auto-repeat.

## Timing
- **Reset values:**
  - Divider 0; `r` 0, so `key_row` = 4'b1110.
  - `key_code` 0, `key_valid` 0, `key_held` 0, `key_digits` 8'h00.
  - State SCAN, `cnt` 0.
- **Reset mid-operation:** all of the above apply immediately and asynchronously. No `key_valid` is emitted, and the partial debounce is discarded.
- **Outputs:** all registered; no combinational path from `key_col` to any output.
- **Press-to-strobe latency** (stable press):
  - 2 clocks of synchronizer.
  - Up to 4 ticks to reach the key's row.
  - DEBOUNCE_TICKS further ticks.
  - `key_valid` rises on the clock edge of the accepting tick.
- **Release latency:** DEBOUNCE_TICKS ticks after the first high sample; `key_held` falls on that tick's edge.
- **Simultaneous events:**
  - A tick coinciding with a debounce abort and a new key in the next row: the new key is detected on the following tick, not the same one.
  - Reset has priority over tick.

## Structure
- **Package `keypad_pkg`:**
  - `kp_state_t` enum: SCAN, DEBOUNCE, HELD, RELEASE.
  - `KP_COLS` = 4, `KP_ROWS` = 4.
  - Function `kp_first_low(col) → [1:0]` (lowest-index low bit).
- **Sub-module `kp_sync2`:** 2-flop synchronizer with parameter WIDTH and reset value, reusable for other board inputs.
- **Stays in the top:** divider, FSM and output registers.

## Test plan
All scenarios use SCAN_DIV_BITS=4 (tick every 16 clocks) and DEBOUNCE_TICKS=3.
- **Reset:** assert `rst_button` mid-DEBOUNCE → `key_row` = 4'b1110, `key_valid` = 0, `key_held` = 0 and `key_digits` = 8'h00 immediately, before the next clock.
- **Idle:** `key_col` = 4'hF for 8 ticks → `key_row` sequence 1110, 1101, 1011, 0111, 1110, …, one change per tick; `key_valid` never high.
- **Clean press:** key row 2 / col 1 pressed (`key_col[1]` low only while `key_row[2]` low) → exactly one `key_valid` pulse, `key_code` = 4'h9, `key_held` = 1; release → `key_held` = 0 three ticks after the first high sample; scanning resumes at row 3.
- **Bounce:** press row 0 / col 3, releasing on the 2nd debounce tick → no `key_valid`. Press row 1 / col 0 stably → `key_code` = 4'h4. Press row 3 / col 2 → `key_code` = 4'hE, `key_digits` = 8'h4E.
- **Contention:** row 1 cols 0 and 2 pressed together → `key_code` = 4'h4 only. While HELD, a key on row 3 is pressed and released → no second `key_valid`.
- **Release bounce:** while HELD, col goes high for one tick then low again → state stays pressed, `key_held` stays 1, no new `key_valid`.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, sizes and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

    localparam int KP_COLS = 4;
    localparam int KP_ROWS = 4;

    function automatic logic [1:0] kp_first_low(input logic [KP_COLS-1:0] col);
        return !col[0] ? 2'd0 : !col[1] ? 2'd1 : !col[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/kp_sync2.sv
// kp_sync2: two-flop synchronizer for asynchronous board inputs.
module kp_sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            q_o    <= RST_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounced press/release,
// key strobe and a two-digit history for the seven-segment driver.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 16,
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic               clk_50M,
    input  logic               rst_button,
    input  logic [KP_COLS-1:0] key_col,
    output logic [KP_ROWS-1:0] key_row,
    output logic [3:0]         key_code,
    output logic               key_valid,
    output logic               key_held,
    output logic [7:0]         key_digits
);

    localparam logic [3:0] DT = 4'(DEBOUNCE_TICKS);

    logic [SCAN_DIV_BITS-1:0] div_q;
    logic [KP_COLS-1:0]       col_s;
    logic                     tick;
    kp_state_t                state_q, state_d;
    logic [1:0]               r_q, r_d, c_q, c_d;
    logic [3:0]               cnt_q, cnt_d, code_q, code_d;
    logic                     valid_q, valid_d, held_q, held_d;
    logic [7:0]               digits_q, digits_d;

    kp_sync2 #(.WIDTH(KP_COLS), .RST_VAL('1)) u_sync (
        .clk_i(clk_50M),
        .rst_i(rst_button),
        .d_i  (key_col),
        .q_o  (col_s)
    );

    assign tick = &div_q;

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        valid_d  = 1'b0;
        held_d   = held_q;
        digits_d = digits_q;
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (&col_s) begin
                        r_d = r_q + 2'd1;
                    end else begin
                        c_d     = kp_first_low(col_s);
                        cnt_d   = 4'd1;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (col_s[c_q]) begin
                        r_d     = r_q + 2'd1;
                        state_d = SCAN;
                    end else if (cnt_q == DT) begin
                        code_d   = {r_q, c_q};
                        digits_d = {digits_q[3:0], r_q, c_q};
                        valid_d  = 1'b1;
                        held_d   = 1'b1;
                        state_d  = HELD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                HELD: begin
                    if (col_s[c_q]) begin
                        cnt_d   = 4'd1;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!col_s[c_q]) begin
                        state_d = HELD;
                    end else if (cnt_q == DT) begin
                        held_d  = 1'b0;
                        r_d     = r_q + 2'd1;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_50M or posedge rst_button) begin
        if (rst_button) begin
            div_q    <= '0;
            state_q  <= SCAN;
            r_q      <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
            digits_q <= '0;
        end else begin
            div_q    <= div_q + 1'b1;
            state_q  <= state_d;
            r_q      <= r_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            held_q   <= held_d;
            digits_q <= digits_d;
        end
    end

    // Row drive depends only on the row register, so it never glitches from key_col.
    assign key_row    = ~(4'b0001 << r_q);
    assign key_code   = code_q;
    assign key_valid  = valid_q;
    assign key_held   = held_q;
    assign key_digits = digits_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench with a 4x4 switch-matrix model driving key_col from key_row.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_col, key_row, key_code;
    logic        key_valid, key_held;
    logic [7:0]  key_digits;
    logic [15:0] press = '0;
    int          checks = 0, failures = 0, vcount = 0;

    keypad_scan #(.SCAN_DIV_BITS(4), .DEBOUNCE_TICKS(3)) dut (
        .clk_50M   (clk),
        .rst_button(rst),
        .key_col   (key_col),
        .key_row   (key_row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .key_digits(key_digits)
    );

    always #5 clk = ~clk;

    // press[r*4+c] closes the switch between row r and column c
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !key_row[r]) key_col[c] = 1'b0;
    end

    always @(negedge clk) if (key_valid) vcount <= vcount + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int maxc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            ok = key_valid;
        end
    endtask

    task automatic wait_held_low(input int maxc, output int n);
        n = 0;
        while (key_held && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_row(input logic [3:0] row, input int maxc, output logic ok);
        ok = (key_row == row);
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            ok = (key_row == row);
        end
    endtask

    initial begin
        logic       ok;
        logic [3:0] prev, one, exp_row;
        int         n, v0, gap;
        one = 4'b0001;
        #1;
        chk("rst_row", key_row, 4'b1110);
        chk("rst_valid", key_valid, 0);
        chk("rst_held", key_held, 0);
        chk("rst_code", key_code, 0);
        chk("rst_digits", key_digits, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle scan: one row step per 16-clock tick
        v0 = vcount;
        prev = key_row;
        for (int i = 1; i <= 8; i++) begin
            n = 0;
            while (key_row == prev && n < 20) begin
                @(negedge clk);
                n++;
            end
            exp_row = ~(one << (i % 4));
            chk("idle_row", key_row, exp_row);
            if (i > 1) chk("idle_gap", n, 16);
            prev = key_row;
        end
        @(negedge clk);
        chk("idle_no_valid", vcount - v0, 0);

        // clean press row 2 col 1
        v0 = vcount;
        press[2*4+1] = 1'b1;
        wait_valid(200, ok);
        chk("p9_seen", ok, 1);
        chk("p9_code", key_code, 4'h9);
        @(negedge clk);
        chk("p9_pulse_len", key_valid, 0);
        chk("p9_held", key_held, 1);
        repeat (80) @(negedge clk);
        chk("p9_one_valid", vcount - v0, 1);
        press = '0;
        wait_held_low(100, n);
        chk("p9_rel_latency", (n >= 48 && n <= 68), 1);
        chk("p9_row_next", key_row, 4'b0111);
        chk("p9_digits", key_digits, 8'h09);

        // bounced press row 0 col 3: released before the 2nd debounce tick samples
        v0 = vcount;
        wait_row(4'b1110, 40, ok);
        chk("b_row0", ok, 1);
        press[0*4+3] = 1'b1;
        repeat (40) @(negedge clk);
        press = '0;
        repeat (100) @(negedge clk);
        chk("b_no_valid", vcount - v0, 0);
        chk("b_code_kept", key_code, 4'h9);

        press[1*4+0] = 1'b1;
        wait_valid(200, ok);
        chk("p4_seen", ok, 1);
        chk("p4_code", key_code, 4'h4);
        press = '0;
        @(negedge clk);
        wait_held_low(100, n);
        chk("p4_released", key_held, 0);

        press[3*4+2] = 1'b1;
        wait_valid(200, ok);
        chk("pe_code", key_code, 4'hE);
        chk("pe_digits", key_digits, 8'h4E);
        press = '0;
        @(negedge clk);
        wait_held_low(100, n);
        chk("pe_released", key_held, 0);

        // contention: two keys in row 1, then a row-3 key while held
        v0 = vcount;
        press[1*4+0] = 1'b1;
        press[1*4+2] = 1'b1;
        wait_valid(200, ok);
        chk("ct_code", key_code, 4'h4);
        chk("ct_digits", key_digits, 8'hE4);
        repeat (20) @(negedge clk);
        press[3*4+1] = 1'b1;
        repeat (64) @(negedge clk);
        press[3*4+1] = 1'b0;
        repeat (32) @(negedge clk);
        chk("ct_held", key_held, 1);
        chk("ct_one_valid", vcount - v0, 1);
        press = '0;
        @(negedge clk);
        wait_held_low(100, n);
        chk("ct_released", key_held, 0);

        // release bounce: column high for exactly one tick while held
        v0 = vcount;
        press[2*4+0] = 1'b1;
        wait_valid(200, ok);
        chk("rb_code", key_code, 4'h8);
        repeat (20) @(negedge clk);
        press = '0;
        repeat (16) @(negedge clk);
        press[2*4+0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            repeat (16) @(negedge clk);
            chk("rb_held", key_held, 1);
        end
        chk("rb_one_valid", vcount - v0, 1);
        chk("rb_code_kept", key_code, 4'h8);
        press = '0;
        @(negedge clk);
        wait_held_low(100, n);
        chk("rb_released", key_held, 0);

        // asynchronous reset in the middle of a debounce
        wait_row(4'b1110, 80, ok);
        press[0] = 1'b1;
        repeat (40) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_row", key_row, 4'b1110);
        chk("ar_valid", key_valid, 0);
        chk("ar_held", key_held, 0);
        chk("ar_digits", key_digits, 8'h00);
        chk("ar_code", key_code, 4'h0);
        press = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
